// File: rtl/madd_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, result DW+1 edges after accept (1 for d==0).
// Accepts only when idle; holds the result until out_ready, then one idle bubble before the next accept.
module madd_divider #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] work_q, work_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rmd_q, rmd_d;
  logic          dz_q, dz_d;

  logic [VW:0]   trial;
  logic          take;
  logic [VW-1:0] rem_nxt;
  logic          last;

  // rem_q < d always, so the shifted trial fits in VW+1 bits and never overflows.
  assign trial   = {rem_q, work_q[DW-1]};
  assign take    = (trial >= {1'b0, dvs_q});
  assign rem_nxt = take ? VW'(trial - {1'b0, dvs_q}) : trial[VW-1:0];
  assign last    = (cnt_q == CW'(DW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (divisor != '0) ? BUSY : DONE;
      BUSY: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    work_d = work_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = dividend;
          dvs_d  = divisor;
          rem_d  = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            quo_d = '1;
            rmd_d = '0;
            dz_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        // The dividend register shifts out numerator bits and shifts in quotient bits.
        work_d = {work_q[DW-2:0], take};
        rem_d  = rem_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          quo_d = {work_q[DW-2:0], take};
          rmd_d = rem_nxt;
          dz_d  = 1'b0;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rmd_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      work_q <= work_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      dz_q   <= dz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_madd_divider.sv
// Randomized bench for madd_divider: results checked against plain integer division,
// with latency, hold-under-backpressure, reset-abort and exhaustive operand sweep.
module tb_madd_divider;
  localparam int DW = 4;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  madd_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation and holds the result for 'hold' cycles before consuming it.
  task automatic run_op(input int n, input int d, input int hold);
    int eq, er, ed, el, lat, waited;
    eq = (d == 0) ? (1 << DW) - 1 : n / d;
    er = (d == 0) ? 0 : n % d;
    ed = (d == 0) ? 1 : 0;
    el = (d == 0) ? 1 : DW + 1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("ready_before_op", int'(in_ready), 1);
    in_valid = 1'b1;
    dividend = DW'(n);
    divisor  = VW'(d);
    lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'($urandom_range(0, 1));
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
    end while (!out_valid && lat < 40);
    check("latency", lat, el);
    check("quotient", int'(quotient), eq);
    check("remainder", int'(remainder), er);
    check("div_zero", int'(div_zero), ed);
    if (d != 0) begin
      check("identity", int'(quotient) * d + int'(remainder), n);
      check("rem_lt_d", int'(int'(remainder) < d), 1);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      in_valid = 1'($urandom_range(0, 1));
      check("hold_valid", int'(out_valid), 1);
      check("hold_ready", int'(in_ready), 0);
      check("hold_quotient", int'(quotient), eq);
      check("hold_remainder", int'(remainder), er);
      check("hold_div_zero", int'(div_zero), ed);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", int'(out_valid), 0);
    check("release_ready", int'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_div_zero", int'(div_zero), 0);

    run_op(13, 3, 0);
    run_op(15, 1, 0);
    run_op(2, 3, 0);
    run_op(7, 0, 0);
    run_op(11, 2, 10);

    // Reset on the second BUSY cycle aborts the operation.
    run_op(14, 3, 0);
    in_valid = 1'b1;
    dividend = DW'(13);
    divisor  = VW'(3);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_div_zero", int'(div_zero), 0);
    for (int i = 0; i < DW + 2; i++) begin
      tick();
      check("abort_no_result", int'(out_valid), 0);
    end
    run_op(9, 2, 1);

    // Reset wins over a simultaneous handshake.
    rst      = 1'b1;
    in_valid = 1'b1;
    dividend = DW'(5);
    divisor  = VW'(1);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_prio_ready", int'(in_ready), 1);
    tick();
    check("rst_prio_ready2", int'(in_ready), 1);
    check("rst_prio_valid", int'(out_valid), 0);

    for (int n = 0; n < (1 << DW); n++) begin
      for (int d = 0; d < (1 << VW); d++) begin
        run_op(n, d, int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/madd_divider.md
MADD_DIVIDER -- requirements
Module: madd_divider

Interface
REQ-001 Parameter DW, default 4, dividend and quotient width in bits.
REQ-002 Parameter VW, default 2, divisor and remainder width in bits; VW <= DW.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  dividend/divisor presented.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 dividend  input  DW  unsigned numerator n.
REQ-008 divisor  input  VW  unsigned denominator d.
REQ-009 out_valid  output  1  result registers hold a finished result.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 quotient  output  DW  unsigned q.
REQ-012 remainder  output  VW  unsigned r.
REQ-013 div_zero  output  1  result came from d == 0.

Function
REQ-014 The block SHALL invert the madd operation: for d != 0, produce q, r with n = q*d + r and r < d.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on the edge where in_valid & in_ready = 1, the block SHALL capture dividend and divisor, then go to BUSY if divisor != 0, else to DONE.
REQ-018 BUSY: restoring division, one quotient bit per cycle, MSB first; partial remainder VW+1 bits wide; iteration counter DW values.
REQ-019 Each BUSY step SHALL shift {partial remainder, next dividend bit} left one bit, subtract d if the result >= d, and set the quotient bit to 1 on subtraction, else 0.
REQ-020 BUSY SHALL last exactly DW cycles; out_valid SHALL rise DW+1 rising edges after the accepting edge.
REQ-021 Divide by zero: out_valid SHALL rise 1 edge after acceptance, with quotient all ones, remainder 0 and div_zero 1.
REQ-022 div_zero SHALL be 0 for every d != 0 result.
REQ-023 DONE: quotient, remainder and div_zero SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-024 DONE with out_ready = 1 SHALL go to IDLE on that edge; in_ready SHALL rise the following cycle (one bubble, no same-cycle accept).
REQ-025 in_valid during BUSY or DONE SHALL be ignored; input ports need not stay stable after acceptance.
REQ-026 Outside DONE, quotient, remainder and div_zero SHALL hold their last values (0 after reset); they are valid only when out_valid = 1.
REQ-027 No arithmetic overflow SHALL occur: the partial remainder never exceeds 2*d-1 within VW+1 bits.

Reset
REQ-028 rst = 1 at a rising edge SHALL force IDLE, in_ready = 1, out_valid = 0, and quotient, remainder, div_zero and internal counters to 0.
REQ-029 rst SHALL override any concurrent handshake; a reset during BUSY or DONE SHALL discard the operation with no result emitted.
REQ-030 rst SHALL take priority over in_valid on the same edge; that operand pair SHALL not be accepted.

Verification
REQ-031 n=13, d=3, out_ready=1 -> out_valid 5 edges after accept, q=4, r=1, div_zero=0.
REQ-032 n=15, d=1 -> q=15, r=0; n=2, d=3 -> q=0, r=2.
REQ-033 n=7, d=0 -> out_valid 1 edge after accept, q=15, r=0, div_zero=1.
REQ-034 Result ready with out_ready held 0 for 10 cycles -> outputs stable, in_ready=0, in_valid pulses ignored; release -> IDLE next edge.
REQ-035 rst asserted on the 2nd BUSY cycle -> next cycle IDLE, out_valid=0, all outputs 0; the following 9/2 operation -> q=4, r=1.
REQ-036 Exhaustive sweep of all 16x4 (n,d) pairs with random out_ready backpressure -> every d != 0 result satisfies q*d + r = n and r < d, and every d = 0 result matches REQ-021.
